// File: rtl/display_pkg.sv
// +----------------------------------------------------------------------+
// | display_pkg : shared helpers and board defaults for the digit scanner |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package display_pkg;

    // Slot and blink defaults for the board clock.
    localparam int DEF_SCAN_DIV  = 1000;
    localparam int DEF_BLINK_DIV = 32;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic an_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// +----------------------------------------------------------------------+
// | tick_divider : enabled modulo-MAX counter with terminal-count pulse   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_divider
    import display_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic                      newclk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic [sel_width(MAX)-1:0] count,
    output logic                      tc
);

    localparam int c_w = sel_width(MAX);

    generate
        if (MAX == 1) begin : g_single
            // Every enabled cycle is a terminal count; no state needed.
            logic unused_clk_rst;
            assign unused_clk_rst = newclk ^ rst_n;
            assign count          = '0;
            assign tc             = en;
        end else begin : g_multi
            localparam logic [c_w-1:0] c_last = c_w'(MAX - 1);
            logic [c_w-1:0] r_count;

            always_ff @(posedge newclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (en) begin
                    r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
                end
            end

            assign count = r_count;
            assign tc    = en && (r_count == c_last);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/digit_scanner.sv
// +----------------------------------------------------------------------+
// | digit_scanner : multiplexed seven-segment strobe with blink/blank     |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module digit_scanner
    import display_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = DEF_SCAN_DIV,
    parameter int BLINK_DIV  = DEF_BLINK_DIV,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                         newclk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [DIGITS-1:0]            blink_mask,
    input  logic [DIGITS-1:0]            blank_mask,
    output logic [sel_width(DIGITS)-1:0] sel,
    output logic [DIGITS-1:0]            an,
    output logic                         frame_start,
    output logic                         blink_phase
);

    localparam int                 c_sel_w    = sel_width(DIGITS);
    localparam int                 c_pre_w    = sel_width(SCAN_DIV);
    localparam int                 c_frm_w    = sel_width(BLINK_DIV);
    localparam logic [c_sel_w-1:0] c_last_sel = c_sel_w'(DIGITS - 1);
    localparam logic               c_act_low  = (ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0]  c_an_off   = {DIGITS{c_act_low}};

    logic [c_pre_w-1:0] w_pre;
    logic               w_slot_tc;
    logic [c_frm_w-1:0] w_frm_unused;
    logic               w_frm_tc;
    logic               w_frame_wrap;
    logic [c_sel_w-1:0] r_sel_cnt;
    logic               r_phase;
    logic [DIGITS-1:0]  w_an_nxt;

    assign w_frame_wrap = w_slot_tc && (r_sel_cnt == c_last_sel);

    tick_divider #(.MAX(SCAN_DIV)) u_slot (
        .newclk (newclk),
        .rst_n  (rst_n),
        .en     (en),
        .count  (w_pre),
        .tc     (w_slot_tc)
    );

    tick_divider #(.MAX(BLINK_DIV)) u_frame (
        .newclk (newclk),
        .rst_n  (rst_n),
        .en     (w_frame_wrap),
        .count  (w_frm_unused),
        .tc     (w_frm_tc)
    );

    // r_sel_cnt/r_phase describe the slot presented on the next edge;
    // the output registers below present it one cycle later.
    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_slot_tc) begin
            r_sel_cnt <= (r_sel_cnt == c_last_sel) ? '0 : r_sel_cnt + 1'b1;
            if (w_frm_tc) begin
                r_phase <= ~r_phase;
            end
        end
    end

    always_comb begin
        w_an_nxt = c_an_off;
        for (int i = 0; i < DIGITS; i++) begin
            if (en && (w_pre != '0) && (r_sel_cnt == c_sel_w'(i)) &&
                !(blank_mask[i] || (blink_mask[i] && r_phase))) begin
                w_an_nxt[DIGITS-1-i] = an_level(1'b1, c_act_low);
            end
        end
    end

    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            an          <= c_an_off;
            frame_start <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            an          <= w_an_nxt;
            frame_start <= en && (w_pre == '0) && (r_sel_cnt == '0);
            if (en) begin
                sel         <= r_sel_cnt;
                blink_phase <= r_phase;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_digit_scanner.sv
// +----------------------------------------------------------------------+
// | tb_digit_scanner : checks digit_scanner against a slot-position model |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_digit_scanner;

    localparam int D  = 8;
    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       en         = 1'b0;
    logic [7:0] blink_mask = '0;
    logic [7:0] blank_mask = '0;

    logic [2:0] sel_lo, sel_hi;
    logic [7:0] an_lo, an_hi;
    logic       fs_lo, fs_hi, bp_lo, bp_hi;

    digit_scanner #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut (
        .newclk      (clk),
        .rst_n       (rst_n),
        .en          (en),
        .blink_mask  (blink_mask),
        .blank_mask  (blank_mask),
        .sel         (sel_lo),
        .an          (an_lo),
        .frame_start (fs_lo),
        .blink_phase (bp_lo)
    );

    digit_scanner #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(0)) dut_hi (
        .newclk      (clk),
        .rst_n       (rst_n),
        .en          (en),
        .blink_mask  (blink_mask),
        .blank_mask  (blank_mask),
        .sel         (sel_hi),
        .an          (an_hi),
        .frame_start (fs_hi),
        .blink_phase (bp_hi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pos counts enabled edges since reset; each one presents slot position pos.
    int         pos     = 0;
    logic [2:0] m_sel   = '0;
    logic       m_phase = 1'b0;
    logic [7:0] m_act   = '0;
    logic       m_fs    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("an_lo", {24'd0, an_lo}, {24'd0, ~m_act});
        check("an_hi", {24'd0, an_hi}, {24'd0, m_act});
        check("sel_lo", {29'd0, sel_lo}, {29'd0, m_sel});
        check("sel_hi", {29'd0, sel_hi}, {29'd0, m_sel});
        check("fs_lo", {31'd0, fs_lo}, {31'd0, m_fs});
        check("fs_hi", {31'd0, fs_hi}, {31'd0, m_fs});
        check("bp_lo", {31'd0, bp_lo}, {31'd0, m_phase});
        check("bp_hi", {31'd0, bp_hi}, {31'd0, m_phase});
    endtask

    task automatic step();
        logic [7:0] bl;
        logic [7:0] bk;
        logic       e;
        int         pre;
        int         slot;
        bl = blink_mask;
        bk = blank_mask;
        e  = en;
        @(posedge clk);
        m_act = '0;
        m_fs  = 1'b0;
        if (e) begin
            pre     = pos % SD;
            slot    = (pos / SD) % D;
            m_sel   = 3'(slot);
            m_phase = ((pos / (SD * D)) / BD) % 2 == 1;
            if (pre != 0 && !bk[slot] && !(bl[slot] && m_phase))
                m_act[D-1-slot] = 1'b1;
            m_fs = (pre == 0) && (slot == 0);
            pos++;
        end
        #1;
        check_model();
    endtask

    // Called 1 time unit after a clock edge (or at time 0).
    task automatic apply_reset();
        #2;
        rst_n   = 1'b0;
        pos     = 0;
        m_sel   = '0;
        m_phase = 1'b0;
        m_act   = '0;
        m_fs    = 1'b0;
        #1;
        check("rst_an_lo", {24'd0, an_lo}, 32'hFF);
        check("rst_an_hi", {24'd0, an_hi}, 32'h00);
        check("rst_sel", {29'd0, sel_lo}, 32'd0);
        check("rst_fs", {31'd0, fs_lo}, 32'd0);
        check("rst_bp", {31'd0, bp_lo}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int last_fs;
        int last_tog;
        logic prev_bp;
        int guard;
        logic found;

        apply_reset();

        // Reset release, masks clear: guard cycle then slot strobes.
        en = 1'b1;
        last_fs = -1;
        for (int c = 0; c < 70; c++) begin
            step();
            if (c == 0) begin
                check("c0_an", {24'd0, an_lo}, 32'hFF);
                check("c0_an_hi", {24'd0, an_hi}, 32'h00);
                check("c0_fs", {31'd0, fs_lo}, 32'd1);
            end
            if (c >= 1 && c <= 3) check("slot0_an", {24'd0, an_lo}, 32'h7F);
            if (c == 1) check("slot0_an_hi", {24'd0, an_hi}, 32'h80);
            if (c >= 5 && c <= 7) begin
                check("slot1_an", {24'd0, an_lo}, 32'hBF);
                check("slot1_sel", {29'd0, sel_lo}, 32'd1);
            end
            if (fs_lo) begin
                if (last_fs >= 0) check("fs_period", 32'(c - last_fs), 32'd32);
                check("fs_sel0", {29'd0, sel_lo}, 32'd0);
                last_fs = c;
            end
        end

        // Blink on digits 4 and 5.
        blink_mask = 8'b0011_0000;
        last_tog = -1;
        prev_bp = bp_lo;
        for (int c = 0; c < 200; c++) begin
            step();
            if (bp_lo !== prev_bp) begin
                if (last_tog >= 0) check("bp_period", 32'(c - last_tog), 32'd64);
                last_tog = c;
            end
            prev_bp = bp_lo;
            if (bp_lo && (sel_lo == 3'd4 || sel_lo == 3'd5))
                check("blink_dark", {24'd0, an_lo}, 32'hFF);
            if (!bp_lo && sel_lo == 3'd4 && ((pos - 1) % SD) != 0)
                check("blink_lit", {24'd0, an_lo}, 32'hF7);
        end

        // Blank overrides blink on digit 0.
        blink_mask = 8'h01;
        blank_mask = 8'h01;
        for (int c = 0; c < 140; c++) begin
            step();
            if (sel_lo == 3'd0) check("blank_s0", {24'd0, an_lo}, 32'hFF);
        end

        // Random enables and mid-slot mask changes.
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) begin
                blink_mask = 8'($urandom);
                blank_mask = 8'($urandom) & 8'($urandom);
            end
            step();
        end

        // Enable dropped with sel=3, pre=2 pending.
        en = 1'b1;
        blink_mask = '0;
        blank_mask = '0;
        apply_reset();
        for (int c = 0; c < 14; c++) step();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("hold_an", {24'd0, an_lo}, 32'hFF);
            check("hold_sel", {29'd0, sel_lo}, 32'd3);
        end
        en = 1'b1;
        step();
        check("resume_sel_a", {29'd0, sel_lo}, 32'd3);
        check("resume_an_a", {24'd0, an_lo}, 32'hEF);
        step();
        check("resume_sel_b", {29'd0, sel_lo}, 32'd3);
        step();
        check("resume_sel4", {29'd0, sel_lo}, 32'd4);
        check("resume_guard", {24'd0, an_lo}, 32'hFF);

        // Async reset mid-frame at sel=6 with blink_phase=1.
        found = 1'b0;
        guard = 0;
        while (!found && guard < 300) begin
            step();
            guard++;
            if (bp_lo && sel_lo == 3'd6) found = 1'b1;
        end
        check("find_sel6_bp1", {31'd0, found}, 32'd1);
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) check("rerelease_fs", {31'd0, fs_lo}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/digit_scanner.md
# digit_scanner

- Parametrised multiplexed seven-segment digit scanner.
- Cycles a one-hot digit strobe across `DIGITS` digits at a programmable slot rate.
- Exports the active digit index, which the segment-data mux uses to pick the value to show.
- Each digit can be blinked or blanked independently from a mask, driven by a frame-based blink timer.
- Sits between the clock/alarm control logic (which supplies edit masks) and the anode pins; it replaces fixed, combinational digit decoding.

## Interface

Parameters:
- `DIGITS`, 8: number of digits scanned; 1..16.
- `SCAN_DIV`, 1000: clock cycles per digit slot; ≥2.
- `BLINK_DIV`, 32: full scan frames per blink half-period; ≥1.
- `ACTIVE_LOW`, 1: 1 = anode strobes active-low; 0 = active-high.

Ports:
- `newclk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable; 0 freezes all counters and turns all digits off.
- `blink_mask` in DIGITS: bit i=1 → digit i blinks.
- `blank_mask` in DIGITS: bit i=1 → digit i permanently dark; overrides blink.
- `sel` out max(1,$clog2(DIGITS)): index of the digit currently strobed, registered.
- `an` out DIGITS: digit strobes, registered; digit i drives `an[DIGITS-1-i]`.
- `frame_start` out 1: one-cycle pulse on the first cycle of slot 0.
- `blink_phase` out 1: 0 = blinking digits lit; 1 = blinking digits dark.

## Operation

- **Slot counter `pre`:** runs 0..SCAN_DIV-1 and wraps. On its terminal count, `sel` advances `sel+1`, wrapping DIGITS-1 → 0.
- **Frame counter `frm`:** advances when `sel` wraps to 0. It runs 0..BLINK_DIV-1; on its terminal count it wraps to 0 and `blink_phase` toggles.
- **Ghost guard:** in the cycle where `pre`=0, every `an` bit is inactive. In cycles `pre`=1..SCAN_DIV-1, the strobe for `sel` is active unless the digit is suppressed.
- **Suppression:** digit `sel` is suppressed when `blank_mask[sel]`=1, or when `blink_mask[sel]`=1 and `blink_phase`=1. While suppressed, `an` is all-inactive.
- **Polarity:** active level is 0 when ACTIVE_LOW=1, 1 when ACTIVE_LOW=0. Inactive is the opposite.
- **Enable low:** `pre`, `sel`, `frm` and `blink_phase` hold their values; `an` is all-inactive and `frame_start`=0.
- **Enable returns high:** counting resumes from the held values.
- **Mask sampling:** masks are sampled every cycle. A change takes effect on `an` in the next cycle, even mid-slot.

## Timing

- **Reset values:** `pre`=0, `sel`=0, `frm`=0, `blink_phase`=0, `frame_start`=0, `an` all-inactive. Asserting `rst_n` mid-frame clears these immediately, without waiting for a clock edge.
- **First cycle after reset release:** a guard cycle of slot 0, with `frame_start`=1 (given `en`=1).
- **`sel` / `an` alignment:** both are registered and change on the same edge. `an` never shows digit k while `sel`≠k.
- **Frame length:** DIGITS×SCAN_DIV cycles. `frame_start` period equals the frame length.
- **Blink half-period:** BLINK_DIV×DIGITS×SCAN_DIV cycles. `blink_phase` toggles on the same edge that produces that frame's `frame_start`.
- **DIGITS=1:** `sel` stays at 0. Every slot wrap is also a frame wrap.

## Structure

- **Package `display_pkg`:**
  - function `sel_width(n)` = max(1,$clog2(n));
  - localparams for default `SCAN_DIV`/`BLINK_DIV` at the board clock;
  - function `an_level(active, ACTIVE_LOW)`.
- **Sub-module `tick_divider`:**
  - parameter `MAX`; inputs `newclk`, `rst_n`, `en`; outputs `count` and a one-cycle `tc` pulse.
  - Instantiated twice: slot counter, and frame counter (enabled by the slot tc at `sel`=DIGITS-1).
- All output registers live in `digit_scanner`.

## Test plan

(DIGITS=8, SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1 unless stated)

- **Reset release, `en`=1, masks 0:**
  - cycle 0: `an`=8'hFF, `sel`=0, `frame_start`=1;
  - cycles 1–3: `an`=8'b01111111;
  - cycles 5–7: `an`=8'b10111111, `sel`=1.
- **Full frame, masks 0:** `sel` runs 0..7, each value held 4 cycles. `frame_start` pulses every 32 cycles exactly when `sel` returns to 0.
- **Blink, `blink_mask`=8'b00110000:**
  - `blink_phase` toggles every 64 cycles.
  - While `blink_phase`=1, slots 4 and 5 give `an`=8'hFF; all other slots are unchanged.
  - While `blink_phase`=0, slot 4 gives 8'b11110111.
- **Blank priority, `blank_mask`=8'h01 and `blink_mask`=8'h01:** slot 0 gives `an`=8'hFF in both blink phases.
- **`en` low for 10 cycles at `sel`=3, `pre`=2:**
  - during: `an`=8'hFF, `sel`=3;
  - after: slot 3 lasts 2 more cycles (`pre`=2,3), then `sel`=4.
- **Async reset and polarity:**
  - `rst_n` pulse mid-frame at `sel`=6, `blink_phase`=1: all state returns to reset values before the next clock edge.
  - With ACTIVE_LOW=0 and the first scenario repeated: the guard cycle gives 8'h00 and slot 0 gives 8'h80.
